keypad_entry: RTL and testbench

Scans a 4x4 matrix keypad, debounces key presses, and builds a two-digit decimal number (0..MAX_VALUE) for operator timing entry in the traffic-light controller. It drives one active-low row line at a time and reads active-low columns. It emits a debounced key strobe and a committed 6-bit `value` with a one-cycle valid pulse. `entry` and `entry_active` feed the seven-segment path: `entry` drives the display value, and the inverse of `entry_active` drives blank.

---
 rtl/keypad_entry.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_keypad_entry.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// Purpose : scans a 4x4 active-low keypad, debounces one key per press and builds a two-digit decimal entry (0..MAX_VALUE).
// Latency : key_strobe one cycle after the frame-ending sample that completes debounce; entry/value/err one cycle after key_strobe.
// Backpr. : none; outputs are single-cycle pulses and level registers, there is no handshake to stall.
//
// Ports:
//   clk, rst_n     system clock, synchronous active-low reset
//   col[3:0]       keypad columns, active-low, asynchronous to clk
//   row[3:0]       row drive, active-low, exactly one bit low
//   key_code[3:0]  code of the last debounced key (0-9, A-D, E = clear, F = enter)
//   key_strobe     one-cycle pulse per debounced press
//   entry[5:0]     in-progress entry value; entry_active high while digits are held
//   value[5:0]     last committed value; value_valid pulses when it updates
//   err            one-cycle pulse when a key is rejected

module keypad_entry #(
    parameter int ROW_CYCLES = 50000,
    parameter int DEB_COUNT  = 4,
    parameter int MAX_VALUE  = 39
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_strobe,
    output logic [5:0] entry,
    output logic       entry_active,
    output logic [5:0] value,
    output logic       value_valid,
    output logic       err
);

    localparam int SLOT_W = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
    localparam int CNT_W  = $clog2(DEB_COUNT + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(ROW_CYCLES - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEB_COUNT);
    localparam logic [6:0]        MAX7      = 7'(MAX_VALUE);

    // Hit counts saturate at MANY: the frame only needs to tell none / one / several.
    localparam logic [1:0] HITS_NONE = 2'd0;
    localparam logic [1:0] HITS_ONE  = 2'd1;
    localparam logic [1:0] HITS_MANY = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_HELD,
        S_REL
    } deb_state_t;

    // Physical key position to key code.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // ------------------------------------------------------------------
    // Column synchronizer (reset to "no key", i.e. all pulled up)
    // ------------------------------------------------------------------
    logic [3:0] col_meta;
    logic [3:0] col_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
        end
    end

    // ------------------------------------------------------------------
    // Row scanner
    // ------------------------------------------------------------------
    logic [SLOT_W-1:0] slot_cnt;
    logic [1:0]        ridx;
    logic              slot_end;
    logic              frame_end;

    assign slot_end  = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_end && (ridx == 2'd3);
    assign row       = ~(4'b0001 << ridx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            ridx     <= 2'd0;
        end else if (slot_end) begin
            slot_cnt <= '0;
            ridx     <= ridx + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + SLOT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Per-slot decode and frame accumulation
    // ------------------------------------------------------------------
    logic [1:0] slot_hits;
    logic [3:0] slot_key;
    logic [1:0] acc_hits;
    logic [3:0] acc_key;
    logic [1:0] frame_hits;
    logic [3:0] frame_key;

    always_comb begin
        slot_hits = HITS_NONE;
        slot_key  = 4'h0;
        for (int c = 0; c < 4; c++) begin
            if (!col_sync[c]) begin
                if (slot_hits == HITS_NONE) begin
                    slot_key  = key_map(ridx, 2'(c));
                    slot_hits = HITS_ONE;
                end else begin
                    slot_hits = HITS_MANY;
                end
            end
        end
    end

    // Running frame result including the slot being sampled this cycle, so the
    // frame-ending sample is judged together with the three before it.
    always_comb begin
        frame_hits = acc_hits;
        frame_key  = acc_key;
        if (slot_hits != HITS_NONE) begin
            if (acc_hits == HITS_NONE) begin
                frame_hits = slot_hits;
                frame_key  = slot_key;
            end else begin
                frame_hits = HITS_MANY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_hits <= HITS_NONE;
            acc_key  <= 4'h0;
        end else if (slot_end) begin
            if (ridx == 2'd3) begin
                acc_hits <= HITS_NONE;
                acc_key  <= 4'h0;
            end else begin
                acc_hits <= frame_hits;
                acc_key  <= frame_key;
            end
        end
    end

    logic res_none;
    logic res_single;

    assign res_none   = (frame_hits == HITS_NONE);
    assign res_single = (frame_hits == HITS_ONE);

    // ------------------------------------------------------------------
    // Debounce FSM, evaluated once per frame
    // ------------------------------------------------------------------
    deb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cand;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            cand       <= 4'h0;
            key_code   <= 4'h0;
            key_strobe <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (frame_end) begin
                case (state)
                    S_IDLE: begin
                        if (res_single) begin
                            cand  <= frame_key;
                            cnt   <= CNT_ONE;
                            state <= S_PRESS;
                        end
                    end
                    S_PRESS: begin
                        // A different single key aborts the press rather than
                        // restarting it; the next frame starts a fresh candidate.
                        if (res_single && (frame_key == cand)) begin
                            if ((cnt + CNT_ONE) == CNT_DONE) begin
                                key_strobe <= 1'b1;
                                key_code   <= cand;
                                state      <= S_HELD;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_HELD: begin
                        if (res_none) begin
                            cnt   <= CNT_ONE;
                            state <= S_REL;
                        end
                    end
                    S_REL: begin
                        if (res_none) begin
                            if ((cnt + CNT_ONE) == CNT_DONE) begin
                                state <= S_IDLE;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end else begin
                            state <= S_HELD;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Two-digit entry
    // ------------------------------------------------------------------
    logic [1:0] digits;
    logic [6:0] next_val;
    logic       is_digit;

    // When a second digit arrives entry holds a single digit (<= 9), so the
    // 7-bit product cannot overflow; the compare happens before truncation.
    assign next_val     = (7'({1'b0, entry}) * 7'd10) + {3'b000, key_code};
    assign is_digit     = (key_code <= 4'd9);
    assign entry_active = (digits != 2'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry       <= 6'd0;
            digits      <= 2'd0;
            value       <= 6'd0;
            value_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            err         <= 1'b0;
            if (key_strobe) begin
                if (is_digit) begin
                    case (digits)
                        2'd0: begin
                            if ({3'b000, key_code} > MAX7) begin
                                err <= 1'b1;
                            end else begin
                                entry  <= {2'b00, key_code};
                                digits <= 2'd1;
                            end
                        end
                        2'd1: begin
                            if (next_val <= MAX7) begin
                                entry  <= next_val[5:0];
                                digits <= 2'd2;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                        default: err <= 1'b1;
                    endcase
                end else if (key_code == 4'hF) begin
                    if (digits != 2'd0) begin
                        value       <= entry;
                        value_valid <= 1'b1;
                        entry       <= 6'd0;
                        digits      <= 2'd0;
                    end else begin
                        err <= 1'b1;
                    end
                end else if (key_code == 4'hE) begin
                    entry  <= 6'd0;
                    digits <= 2'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Purpose : self-checking bench for keypad_entry using a frame-level behavioural keypad/entry model.
// Latency : each stimulus step lasts one whole scan frame; results are checked at fixed frame offsets.
// Backpr. : none; the bench only drives the keypad matrix and reset.

module tb_keypad_entry;

    localparam int RC    = 8;
    localparam int DEB   = 3;
    localparam int MAXV  = 39;
    localparam int FRAME = 4 * RC;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_strobe;
    logic [5:0] entry;
    logic       entry_active;
    logic [5:0] value;
    logic       value_valid;
    logic       err;

    logic [15:0] pressed;

    keypad_entry #(
        .ROW_CYCLES(RC),
        .DEB_COUNT (DEB),
        .MAX_VALUE (MAXV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .col         (col),
        .row         (row),
        .key_code    (key_code),
        .key_strobe  (key_strobe),
        .entry       (entry),
        .entry_active(entry_active),
        .value       (value),
        .value_valid (value_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Switch matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (row[r] == 1'b0 && pressed[r*4+c]) col[c] = 1'b0;
    end

    // Key legend by bit position r*4+c.
    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

    int n_cmp = 0;
    int n_bad = 0;

    // Observed pulse totals, used by the directed steps.
    int obs_strobes = 0;
    int obs_vv      = 0;
    int obs_err     = 0;

    // Reference model state.
    int         m_locked, m_run_len, m_none_len;
    logic [3:0] m_run_key;
    int         m_digits, m_entry, m_value;
    bit         exp_strobe;
    logic [3:0] exp_code;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] key_mask(input logic [3:0] k);
        logic [15:0] m;
        m = 16'h0;
        for (int i = 0; i < 16; i++) if (kmap[i] == k) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [3:0] exp_row(input int k);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << (k / RC));
    endfunction

    task automatic model_reset();
        m_locked   = 0;
        m_run_len  = 0;
        m_none_len = 0;
        m_run_key  = 4'h0;
        m_digits   = 0;
        m_entry    = 0;
        m_value    = 0;
        exp_strobe = 1'b0;
        exp_code   = 4'h0;
    endtask

    // Debounce: a key is accepted after DEB consecutive frames of exactly that
    // single key; afterwards DEB consecutive empty frames are needed to re-arm.
    task automatic model_frame(input logic [15:0] m);
        int         hits;
        logic [3:0] k;
        hits = $countones(m);
        k    = 4'h0;
        for (int i = 0; i < 16; i++) if (m[i]) k = kmap[i];
        exp_strobe = 1'b0;
        if (m_locked != 0) begin
            if (hits == 0) begin
                m_none_len++;
                if (m_none_len == DEB) begin
                    m_locked  = 0;
                    m_run_len = 0;
                end
            end else begin
                m_none_len = 0;
            end
        end else if (hits == 1 && (m_run_len == 0 || k == m_run_key)) begin
            m_run_key = k;
            m_run_len++;
            if (m_run_len == DEB) begin
                exp_strobe = 1'b1;
                exp_code   = k;
                m_locked   = 1;
                m_none_len = 0;
            end
        end else begin
            m_run_len = 0;
        end
    endtask

    // Entry rules applied to one accepted key; returns the expected pulses.
    task automatic model_key(input logic [3:0] k, output bit vv, output bit er);
        int d;
        d  = int'(k);
        vv = 1'b0;
        er = 1'b0;
        if (d <= 9) begin
            if (m_digits == 0) begin
                if (d > MAXV) er = 1'b1;
                else begin m_entry = d; m_digits = 1; end
            end else if (m_digits == 1) begin
                if (m_entry * 10 + d <= MAXV) begin m_entry = m_entry * 10 + d; m_digits = 2; end
                else er = 1'b1;
            end else begin
                er = 1'b1;
            end
        end else if (d == 15) begin
            if (m_digits > 0) begin
                m_value = m_entry; vv = 1'b1; m_entry = 0; m_digits = 0;
            end else begin
                er = 1'b1;
            end
        end else if (d == 14) begin
            m_entry = 0; m_digits = 0;
        end
    endtask

    // One scan frame with the given keys held. Called at the first cycle of a
    // frame (just after its first clock edge); returns at the first cycle of
    // the next frame.
    task automatic run_frame(input logic [15:0] m);
        int extra;
        bit vv, er;
        extra = 0;
        // cycle 0: strobe from the previous frame's last sample
        check("row", row, exp_row(0));
        check("key_strobe", key_strobe, exp_strobe);
        if (exp_strobe) check("key_code", key_code, exp_code);
        if (key_strobe) obs_strobes++;
        if (value_valid || err) extra++;
        pressed = m;
        @(negedge clk);
        // cycle 1: entry outputs react to that strobe
        vv = 1'b0;
        er = 1'b0;
        if (exp_strobe) model_key(exp_code, vv, er);
        check("row", row, exp_row(1));
        check("entry", entry, m_entry);
        check("entry_active", entry_active, (m_digits != 0));
        check("value", value, m_value);
        check("value_valid", value_valid, vv);
        check("err", err, er);
        if (value_valid) obs_vv++;
        if (err) obs_err++;
        if (key_strobe) extra++;
        for (int k = 2; k < FRAME; k++) begin
            @(negedge clk);
            check("row", row, exp_row(k));
            if (key_strobe || value_valid || err) extra++;
        end
        check("stray_pulses", extra, 0);
        @(negedge clk);
        model_frame(m);
    endtask

    task automatic hold(input logic [15:0] m, input int n);
        for (int i = 0; i < n; i++) run_frame(m);
    endtask

    task automatic press(input logic [3:0] k);
        hold(key_mask(k), DEB);
        hold(16'h0, DEB);
    endtask

    // Reset asserted at a frame boundary for three clock edges.
    task automatic do_reset(input logic [15:0] m);
        rst_n   = 1'b0;
        pressed = m;
        repeat (3) @(negedge clk);
        check("rst_row", row, 4'b1110);
        check("rst_key_code", key_code, 0);
        check("rst_key_strobe", key_strobe, 0);
        check("rst_entry", entry, 0);
        check("rst_entry_active", entry_active, 0);
        check("rst_value", value, 0);
        check("rst_value_valid", value_valid, 0);
        check("rst_err", err, 0);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        int s0, v0, e0;
        logic [15:0] m;
        int a, b, r;

        pressed = 16'h0;
        model_reset();
        do_reset(16'h0);

        // Idle frame: row rotation checked every cycle.
        run_frame(16'h0);

        // Key 2 held for six frames gives exactly one strobe.
        s0 = obs_strobes;
        hold(key_mask(4'h2), 6);
        hold(16'h0, DEB);
        check("k2_strobes", obs_strobes - s0, 1);
        check("k2_code", key_code, 2);
        check("k2_entry", entry, 2);
        check("k2_active", entry_active, 1);

        // Clear, then 3 5 # commits 35.
        press(4'hE);
        press(4'h3);
        press(4'h5);
        v0 = obs_vv;
        press(4'hF);
        check("v35_value", value, 35);
        check("v35_pulses", obs_vv - v0, 1);
        check("v35_entry", entry, 0);
        check("v35_active", entry_active, 0);

        // 4 then 5 overflows (45 > 39); entry stays 4 and # commits 4.
        e0 = obs_err;
        press(4'h4);
        press(4'h5);
        check("ovf_err", obs_err - e0, 1);
        check("ovf_entry", entry, 4);
        press(4'hF);
        check("v4_value", value, 4);

        // Bounce on key 7: 2 frames, gap, 3 frames -> one strobe.
        s0 = obs_strobes;
        hold(key_mask(4'h7), 2);
        hold(16'h0, 1);
        hold(key_mask(4'h7), 2);
        check("bounce_early", obs_strobes - s0, 0);
        hold(key_mask(4'h7), 1);
        run_frame(key_mask(4'h7));
        check("bounce_strobes", obs_strobes - s0, 1);
        hold(16'h0, DEB);

        // Keys 7 and 8 together never strobe.
        s0 = obs_strobes;
        hold(key_mask(4'h7) | key_mask(4'h8), 5);
        hold(16'h0, DEB);
        check("multi_strobes", obs_strobes - s0, 0);

        // 1 2 then clear: no commit; # on empty entry is an error.
        press(4'hE);
        press(4'h1);
        press(4'h2);
        check("e12_entry", entry, 12);
        v0 = obs_vv;
        press(4'hE);
        check("clr_entry", entry, 0);
        check("clr_no_vv", obs_vv - v0, 0);
        e0 = obs_err;
        press(4'hF);
        check("empty_enter_err", obs_err - e0, 1);

        // Reset while a key is held: outputs return to reset, no strobe on release.
        press(4'h9);
        hold(key_mask(4'hA), DEB + 1);
        do_reset(key_mask(4'hA));
        s0 = obs_strobes;
        run_frame(key_mask(4'hA));
        hold(16'h0, DEB + 1);
        check("rst_release_strobes", obs_strobes - s0, 0);

        // Randomized key activity checked against the model frame by frame.
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
                m = 16'h0;
            end else if (r < 8) begin
                m = 16'h0;
                m[$urandom_range(0, 15)] = 1'b1;
            end else begin
                a = $urandom_range(0, 15);
                b = $urandom_range(0, 15);
                m = 16'h0;
                m[a] = 1'b1;
                m[b] = 1'b1;
            end
            hold(m, $urandom_range(1, 5));
        end
        hold(16'h0, DEB + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
